// File: rtl/front_panel_loader_pkg.sv
// Shared encodings for the front-panel loader: selected field and deposit FSM states.
package front_panel_loader_pkg;

    typedef enum logic [1:0] {
        FIELD_ADDR    = 2'd0,
        FIELD_DATA_HI = 2'd1,
        FIELD_DATA_LO = 2'd2
    } field_e;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_DRIVE_ADDR = 2'd1,
        ST_DRIVE_DATA = 2'd2,
        ST_ADVANCE    = 2'd3
    } state_e;

    function automatic field_e next_field(input field_e f);
        case (f)
            FIELD_ADDR:    return FIELD_DATA_HI;
            FIELD_DATA_HI: return FIELD_DATA_LO;
            default:       return FIELD_ADDR;
        endcase
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Level filter for one raw button: the output follows the input only after
// DEBOUNCE_CYCLES consecutive samples at the new level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            count <= '0;
        end else if (btn == level) begin
            count <= '0;
        end else if (count == CNT_LAST) begin
            level <= btn;
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/front_panel_loader.sv
// Front-panel loader: debounced buttons edit address/data and run a MAR/RAM deposit sequence.
// Optional macro LOADER_AUTOINC_EN: advance the address after each completed deposit.
module front_panel_loader
    import front_panel_loader_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int ADDRESS_WIDTH   = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                     i_SYS_CLOCK,
    input  logic                     i_CLEAR,
    input  logic                     i_ENABLE,
    input  logic                     i_BTN_VALUE,
    input  logic                     i_BTN_FIELD,
    input  logic                     i_BTN_DEPOSIT,
    output logic [DATA_WIDTH-1:0]    o_BUS,
    output logic                     o_BUS_DRIVE,
    output logic                     o_MAR_IN,
    output logic                     o_RAM_IN,
    output logic                     o_BUSY,
    output logic                     o_DONE,
    output logic [ADDRESS_WIDTH-1:0] o_ADDRESS,
    output logic [DATA_WIDTH-1:0]    o_DATA,
    output logic [1:0]               o_FIELD
);

    localparam int LO_W = DATA_WIDTH / 2;

    logic lvl_value, lvl_field, lvl_deposit;
    logic prev_value, prev_field, prev_deposit;
    logic accept, ev_value, ev_field, ev_deposit;

    state_e                   state;
    field_e                   field;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    data;
    logic [DATA_WIDTH-1:0]    bus_q;
    logic                     drive_q, mar_q, ram_q, done_q;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_value (
        .clk(i_SYS_CLOCK), .rst(i_CLEAR), .btn(i_BTN_VALUE), .level(lvl_value)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_field (
        .clk(i_SYS_CLOCK), .rst(i_CLEAR), .btn(i_BTN_FIELD), .level(lvl_field)
    );
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_deposit (
        .clk(i_SYS_CLOCK), .rst(i_CLEAR), .btn(i_BTN_DEPOSIT), .level(lvl_deposit)
    );

    // Edges seen while busy or disabled are consumed by the prev_* registers, never queued.
    always_comb begin
        accept     = i_ENABLE && (state == ST_IDLE);
        ev_deposit = accept && lvl_deposit && !prev_deposit;
        ev_field   = accept && lvl_field   && !prev_field;
        ev_value   = accept && lvl_value   && !prev_value;
    end

    always_ff @(posedge i_SYS_CLOCK or posedge i_CLEAR) begin
        if (i_CLEAR) begin
            prev_value   <= 1'b0;
            prev_field   <= 1'b0;
            prev_deposit <= 1'b0;
            state        <= ST_IDLE;
            field        <= FIELD_ADDR;
            address      <= '0;
            data         <= '0;
            bus_q        <= '0;
            drive_q      <= 1'b0;
            mar_q        <= 1'b0;
            ram_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            prev_value   <= lvl_value;
            prev_field   <= lvl_field;
            prev_deposit <= lvl_deposit;
            bus_q        <= '0;
            drive_q      <= 1'b0;
            mar_q        <= 1'b0;
            ram_q        <= 1'b0;
            done_q       <= 1'b0;
            if (!i_ENABLE) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ev_deposit) begin
                            state   <= ST_DRIVE_ADDR;
                            bus_q   <= DATA_WIDTH'(address);
                            drive_q <= 1'b1;
                            mar_q   <= 1'b1;
                        end else if (ev_field) begin
                            field <= next_field(field);
                        end else if (ev_value) begin
                            case (field)
                                FIELD_ADDR:    address <= address + 1'b1;
                                FIELD_DATA_HI: data[DATA_WIDTH-1:LO_W] <= data[DATA_WIDTH-1:LO_W] + 1'b1;
                                default:       data[LO_W-1:0] <= data[LO_W-1:0] + 1'b1;
                            endcase
                        end
                    end
                    ST_DRIVE_ADDR: begin
                        state   <= ST_DRIVE_DATA;
                        bus_q   <= data;
                        drive_q <= 1'b1;
                        ram_q   <= 1'b1;
                    end
                    ST_DRIVE_DATA: begin
                        state  <= ST_ADVANCE;
                        done_q <= 1'b1;
                    end
                    default: begin
                        state <= ST_IDLE;
`ifdef LOADER_AUTOINC_EN
                        address <= address + 1'b1;
`endif
                    end
                endcase
            end
        end
    end

    // Enable gates the registered strobes so a falling i_ENABLE releases the bus in the same cycle.
    always_comb begin
        o_BUS_DRIVE = drive_q && i_ENABLE;
        o_MAR_IN    = mar_q && i_ENABLE;
        o_RAM_IN    = ram_q && i_ENABLE;
        o_DONE      = done_q && i_ENABLE;
        o_BUS       = o_BUS_DRIVE ? bus_q : '0;
        o_BUSY      = (state != ST_IDLE);
        o_ADDRESS   = address;
        o_DATA      = data;
        o_FIELD     = field;
    end

endmodule

// File: tb/tb_front_panel_loader.sv
// Self-checking bench for front_panel_loader (DEBOUNCE_CYCLES = 4); honours LOADER_AUTOINC_EN.
module tb_front_panel_loader;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       enable = 1'b1;
    logic       b_value = 1'b0, b_field = 1'b0, b_deposit = 1'b0;
    logic [7:0] bus, dout;
    logic [3:0] addr;
    logic [1:0] fld;
    logic       drive, mar_in, ram_in, busy, done;

    int total = 0;
    int bad = 0;

    // Reference model state
    int exp_addr = 0;
    int exp_data = 0;
    int exp_field = 0;

    front_panel_loader #(
        .DATA_WIDTH(8),
        .ADDRESS_WIDTH(4),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .i_SYS_CLOCK(clk),
        .i_CLEAR(clear),
        .i_ENABLE(enable),
        .i_BTN_VALUE(b_value),
        .i_BTN_FIELD(b_field),
        .i_BTN_DEPOSIT(b_deposit),
        .o_BUS(bus),
        .o_BUS_DRIVE(drive),
        .o_MAR_IN(mar_in),
        .o_RAM_IN(ram_in),
        .o_BUSY(busy),
        .o_DONE(done),
        .o_ADDRESS(addr),
        .o_DATA(dout),
        .o_FIELD(fld)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Invariants that must hold in every cycle.
    always @(negedge clk) begin
        chk("mar_ram_exclusive", 32'(mar_in && ram_in), 32'd0);
        chk("drive_needs_enable", 32'(drive && !enable), 32'd0);
        chk("bus_zero_undriven", (!drive) ? 32'(bus) : 32'd0, 32'd0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            0: b_value = v;
            1: b_field = v;
            default: b_deposit = v;
        endcase
    endtask

    task automatic model_event(input int which);
        case (which)
            0: begin
                if (exp_field == 0)
                    exp_addr = (exp_addr + 1) % 16;
                else if (exp_field == 1)
                    exp_data = ((((exp_data / 16) + 1) % 16) * 16) + (exp_data % 16);
                else
                    exp_data = (exp_data / 16) * 16 + (((exp_data % 16) + 1) % 16);
            end
            1: exp_field = (exp_field + 1) % 3;
            default: begin
`ifdef LOADER_AUTOINC_EN
                exp_addr = (exp_addr + 1) % 16;
`endif
            end
        endcase
    endtask

    task automatic press(input int which, input int hold);
        set_btn(which, 1'b1);
        repeat (hold) tick();
        set_btn(which, 1'b0);
        repeat (DEB + 2) tick();
    endtask

    task automatic press_model(input int which);
        press(which, DEB + 2);
        model_event(which);
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_addr"}, 32'(addr), 32'(exp_addr));
        chk({tag, "_data"}, 32'(dout), 32'(exp_data));
        chk({tag, "_field"}, 32'(fld), 32'(exp_field));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    int  which, hold, r;
    bit  en_now;
    bit  ram_seen, done_seen;

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_bus", 32'(bus), 32'd0);
        chk("rst_drive", 32'(drive), 32'd0);
        chk("rst_strobes", 32'({mar_in, ram_in, busy, done}), 32'd0);
        check_model("rst");
        clear = 1'b0;
        tick();

        // Short pulse ignored, long hold accepted
        press(0, 2);
        chk("pulse_ignored", 32'(addr), 32'd0);
        press_model(0);
        chk("hold_accepted", 32'(addr), 32'd1);

        // Data entry: FIELD, VALUE x3, FIELD, VALUE x10
        press_model(1);
        repeat (3) press_model(0);
        press_model(1);
        repeat (10) press_model(0);
        chk("entry_data", 32'(dout), 32'h3A);
        chk("entry_field", 32'(fld), 32'd2);
        check_model("entry");

        // Address 5 and deposit timing
        press_model(1);
        while (exp_addr != 5) press_model(0);
        chk("addr5", 32'(addr), 32'd5);
        b_deposit = 1'b1;
        repeat (DEB) tick();
        chk("pre_dep_busy", 32'(busy), 32'd0);
        tick();
        chk("n1_bus", 32'(bus), 32'h05);
        chk("n1_strobes", 32'({drive, mar_in, ram_in, busy, done}), 32'b11010);
        tick();
        chk("n2_bus", 32'(bus), 32'h3A);
        chk("n2_strobes", 32'({drive, mar_in, ram_in, busy, done}), 32'b10110);
        tick();
        chk("n3_bus", 32'(bus), 32'h00);
        chk("n3_strobes", 32'({drive, mar_in, ram_in, busy, done}), 32'b00011);
        tick();
        chk("n4_idle", 32'({drive, mar_in, ram_in, busy, done}), 32'b00000);
        model_event(2);
`ifdef LOADER_AUTOINC_EN
        chk("dep_addr_after", 32'(addr), 32'd6);
`else
        chk("dep_addr_after", 32'(addr), 32'd5);
`endif
        b_deposit = 1'b0;
        repeat (DEB + 2) tick();
        check_model("dep1");

        // Address wrap on deposit at 15, nibble wrap without carry
        while (exp_addr != 15) press_model(0);
        press_model(2);
`ifdef LOADER_AUTOINC_EN
        chk("wrap_addr", 32'(addr), 32'd0);
`else
        chk("wrap_addr", 32'(addr), 32'd15);
`endif
        press_model(1);
        press_model(1);
        while (exp_data % 16 != 15) press_model(0);
        chk("lo_at_f", 32'(dout), 32'h3F);
        press_model(0);
        chk("lo_wrap", 32'(dout), 32'h30);
        check_model("wrap");

        // DEPOSIT and VALUE debounced on the same edge: deposit wins
        b_deposit = 1'b1;
        b_value = 1'b1;
        repeat (DEB + 1) tick();
        chk("simul_busy", 32'(busy), 32'd1);
        tick();
        b_deposit = 1'b0;
        b_value = 1'b0;
        repeat (DEB + 2) tick();
        model_event(2);
        check_model("simul");

        // VALUE rising during BUSY is dropped
        b_deposit = 1'b1;
        tick();
        b_value = 1'b1;
        repeat (DEB + 3) tick();
        b_deposit = 1'b0;
        b_value = 1'b0;
        repeat (DEB + 2) tick();
        model_event(2);
        check_model("busy_drop");

        // Enable dropped in DRIVE_ADDR
        b_deposit = 1'b1;
        repeat (DEB + 1) tick();
        chk("abort_mar", 32'(mar_in), 32'd1);
        enable = 1'b0;
        #1;
        chk("abort_drive_now", 32'(drive), 32'd0);
        ram_seen = 1'b0;
        done_seen = 1'b0;
        tick();
        chk("abort_idle", 32'(busy), 32'd0);
        repeat (4) begin
            ram_seen |= ram_in;
            done_seen |= done;
            tick();
        end
        chk("abort_no_ram", 32'(ram_seen), 32'd0);
        chk("abort_no_done", 32'(done_seen), 32'd0);
        b_deposit = 1'b0;
        repeat (DEB + 2) tick();
        enable = 1'b1;
        tick();
        check_model("abort");

        // Clear in DRIVE_DATA: immediate, and deposit held through release needs a full window
        b_deposit = 1'b1;
        repeat (DEB + 2) tick();
        chk("clr_in_ram", 32'(ram_in), 32'd1);
        clear = 1'b1;
        #1;
        chk("clr_now_bus", 32'(bus), 32'd0);
        chk("clr_now_strobes", 32'({drive, mar_in, ram_in, busy, done}), 32'd0);
        exp_addr = 0;
        exp_data = 0;
        exp_field = 0;
        check_model("clr_now");
        tick();
        clear = 1'b0;
        repeat (DEB) tick();
        chk("held_not_yet", 32'(busy), 32'd0);
        tick();
        chk("held_fires", 32'({mar_in, busy}), 32'b11);
        b_deposit = 1'b0;
        repeat (DEB + 2) tick();
        model_event(2);
        check_model("held");

        // Randomized presses against the reference model
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            which = (r < 5) ? 0 : ((r < 8) ? 1 : 2);
            hold = $urandom_range(1, 7);
            en_now = ($urandom_range(0, 7) != 0);
            enable = en_now;
            press(which, hold);
            enable = 1'b1;
            tick();
            if (en_now && hold >= DEB) model_event(which);
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/front_panel_loader.md
FRONT_PANEL_LOADER -- requirements
Module: front_panel_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bus and RAM word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 4: RAM address width.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable samples required to accept a button level.
REQ-004 SHALL have one clock and an asynchronous active-high reset:
- i_SYS_CLOCK  in  1  clock; the same clock drives MAR and RAM while loading.
- i_CLEAR  in  1  asynchronous active-high reset.
REQ-005 SHALL have these further ports:
- i_ENABLE  in  1  loader mode; CPU halted.
- i_BTN_VALUE  in  1  raw button; increments the selected field.
- i_BTN_FIELD  in  1  raw button; cycles the selected field.
- i_BTN_DEPOSIT  in  1  raw button; writes the data word to RAM.
- o_BUS  out  DATA_WIDTH  value driven onto the CPU bus.
- o_BUS_DRIVE  out  1  bus driver enable.
- o_MAR_IN  out  1  MAR latch strobe.
- o_RAM_IN  out  1  RAM write strobe.
- o_BUSY  out  1  deposit sequence in progress.
- o_DONE  out  1  one-cycle pulse when a deposit completes.
- o_ADDRESS  out  ADDRESS_WIDTH  current address, for the display.
- o_DATA  out  DATA_WIDTH  current data word, for the display.
- o_FIELD  out  2  selected field: 0 = ADDR, 1 = DATA_HI, 2 = DATA_LO.

Function
REQ-006 SHALL pass each button through a debouncer: the output level changes only after the input holds the new level for DEBOUNCE_CYCLES consecutive cycles.
REQ-007 SHALL act only on the rising edge of a debounced level, one event per press.
REQ-008 SHALL ignore all button events while i_ENABLE = 0 or o_BUSY = 1; dropped events are not queued.
REQ-009 SHALL resolve simultaneous events by priority DEPOSIT > FIELD > VALUE and drop the lower-priority events.
REQ-010 On a FIELD event, SHALL step the field ADDR -> DATA_HI -> DATA_LO -> ADDR.
REQ-011 On a VALUE event, SHALL increment the selected field modulo its width: address 15 -> 0; a data nibble F -> 0 without carrying into the other nibble.
REQ-012 SHALL sequence a deposit with FSM states IDLE, DRIVE_ADDR, DRIVE_DATA, ADVANCE, each non-IDLE state lasting exactly one cycle.
REQ-013 A DEPOSIT event registered at edge N SHALL give the following timing:
- DRIVE_ADDR during cycle N+1: o_BUS = zero-extended address, o_BUS_DRIVE = 1, o_MAR_IN = 1.
- DRIVE_DATA during N+2: o_BUS = data, o_BUS_DRIVE = 1, o_RAM_IN = 1.
- ADVANCE during N+3: o_BUS_DRIVE = 0, o_DONE = 1.
- IDLE from N+4.
REQ-014 o_BUSY SHALL be 1 exactly in DRIVE_ADDR, DRIVE_DATA and ADVANCE.
REQ-015 o_MAR_IN and o_RAM_IN SHALL never be asserted in the same cycle.
REQ-016 o_BUS_DRIVE SHALL never be asserted while i_ENABLE = 0.
REQ-017 SHALL drive o_BUS to 0 whenever o_BUS_DRIVE = 0.
REQ-018 If i_ENABLE falls mid-sequence, SHALL return to IDLE at the next edge with all strobes deasserted, no o_DONE pulse, and the address unchanged.

Reset
REQ-019 While i_CLEAR = 1, SHALL hold:
- FSM in IDLE, o_FIELD = 0, o_ADDRESS = 0, o_DATA = 0;
- all strobes, o_BUSY and o_DONE at 0, o_BUS = 0;
- debouncer levels and counters at 0.
REQ-020 A button held through reset release SHALL require a full DEBOUNCE_CYCLES window to count as pressed.
REQ-021 Reset asserted mid-deposit SHALL take effect immediately and asynchronously, with no further strobes.

Configuration
REQ-022 With macro LOADER_AUTOINC_EN defined, ADVANCE SHALL increment the address modulo 2^ADDRESS_WIDTH; without it, the address SHALL be unchanged after a deposit.

Structure
REQ-023 SHALL place the field encoding (ADDR/DATA_HI/DATA_LO) and FSM state encoding in the shared package.
REQ-024 SHALL instantiate one sub-module, button_debouncer, three times; the debouncer does level filtering, and edge detection stays in the parent.

Verification (bench with DEBOUNCE_CYCLES = 4)
REQ-025 Reset, then pulse VALUE for 2 cycles -> no change; hold 6 cycles -> o_ADDRESS 0 -> 1.
REQ-026 FIELD once, VALUE x3, FIELD, VALUE x10 -> o_DATA = 8'h3A, o_FIELD = 2.
REQ-027 Address 5, data 8'h3A, DEPOSIT -> cycle N+1: o_BUS = 8'h05 with o_MAR_IN; N+2: o_BUS = 8'h3A with o_RAM_IN; N+3: o_DONE; then o_ADDRESS = 6 with LOADER_AUTOINC_EN, 5 without.
REQ-028 Address 15, DEPOSIT with LOADER_AUTOINC_EN -> o_ADDRESS = 0; DATA_LO at F, VALUE -> low nibble 0 and high nibble unchanged.
REQ-029 DEPOSIT and VALUE debounced on the same edge -> deposit runs and the value is unchanged; VALUE during BUSY -> dropped.
REQ-030 Drop i_ENABLE in DRIVE_ADDR -> IDLE at the next edge, o_RAM_IN never asserted, no o_DONE; repeat with i_CLEAR in DRIVE_DATA -> outputs 0 immediately.
